// File: rtl/truth_table_sequencer.sv
// Clocked truth-table sweep: drives every input vector 0..2^N_IN-1 to a small
// combinational block, samples its output after HOLD cycles and packs the results.
module truth_table_sequencer #(
    parameter int N_IN = 2,
    parameter int HOLD = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   dut_y,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   result
);

    localparam int NV = 1 << N_IN;
    localparam int IW = N_IN + 1;
    localparam int HW = $clog2(HOLD) + 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(NV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [N_IN-1:0]   vec_out_q, vec_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NV-1:0]     result_q, result_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        vec_out_d  = vec_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                vec_out_d = '0;
                busy_d    = 1'b0;
                if (start) begin
                    state_d    = DRIVE;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                    result_d   = '0;
                    busy_d     = 1'b1;
                end
            end
            DRIVE: begin
                // Outputs are registered, so the next vector is loaded on the
                // same edge that captures the current one.
                if (hold_cnt_q == HOLD_LAST) begin
                    result_d[idx_q[N_IN-1:0]] = dut_y;
                    hold_cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        vec_out_d = '0;
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        vec_out_d = idx_d[N_IN-1:0];
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                vec_out_d = '0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            vec_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            vec_out_q  <= vec_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign vec_out = vec_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized scoreboard bench for truth_table_sequencer: two instances
// (N_IN=2/HOLD=10 and N_IN=3/HOLD=1) sweeping behavioural gate functions.
module tb_truth_table_sequencer;

    localparam int NA = 2;
    localparam int HA = 10;
    localparam int NB = 3;
    localparam int HB = 1;
    localparam int LEN_A = (1 << NA) * HA;
    localparam int LEN_B = (1 << NB) * HB;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic              start_a;
    logic              dut_y_a;
    logic [NA-1:0]     vec_a;
    logic              busy_a;
    logic              done_a;
    logic [(1<<NA)-1:0] result_a;
    int                sel_a;
    logic [7:0]        tt_a;

    // Instance B signals
    logic              start_b;
    logic              dut_y_b;
    logic [NB-1:0]     vec_b;
    logic              busy_b;
    logic              done_b;
    logic [(1<<NB)-1:0] result_b;
    int                sel_b;
    logic [7:0]        tt_b;

    logic [31:0] exp_res_a[$];
    logic [31:0] exp_vec_a[$];
    logic [31:0] exp_res_b[$];
    logic [31:0] exp_vec_b[$];

    // Gate functions evaluated on the integer value of the input vector:
    // 0 = AND of all inputs, 1 = XOR, 2 = OR, 3 = arbitrary random table.
    function automatic logic gate_eval(int sel, int v, int n, logic [7:0] tt);
        case (sel)
            0:       return (v == (1 << n) - 1);
            1:       return ($countones(v) % 2) == 1;
            2:       return (v != 0);
            default: return tt[v];
        endcase
    endfunction

    function automatic logic [31:0] sweep_model(int sel, int n, logic [7:0] tt);
        logic [31:0] r = '0;
        for (int k = 0; k < (1 << n); k++) r[k] = gate_eval(sel, k, n, tt);
        return r;
    endfunction

    assign dut_y_a = gate_eval(sel_a, int'(vec_a), NA, tt_a);
    assign dut_y_b = gate_eval(sel_b, int'(vec_b), NB, tt_b);

    truth_table_sequencer #(.N_IN(NA), .HOLD(HA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_y(dut_y_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .result(result_a)
    );

    truth_table_sequencer #(.N_IN(NB), .HOLD(HB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_y(dut_y_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .result(result_b)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitors: pop expected vectors while busy, expected results on done.
    int busy_cnt_a = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_a) begin
                busy_cnt_a++;
                if (exp_vec_a.size() == 0) report_fail("vec_a_unexpected_busy");
                else check("vec_a", 32'(vec_a), exp_vec_a.pop_front());
            end
            if (done_a) begin
                check("busy_len_a", busy_cnt_a, LEN_A);
                check("done_vec_a", 32'(vec_a), 0);
                if (exp_res_a.size() == 0) report_fail("result_a_unexpected_done");
                else check("result_a", 32'(result_a), exp_res_a.pop_front());
            end
            if (!busy_a) busy_cnt_a = 0;
        end
    end

    int busy_cnt_b = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_b) begin
                busy_cnt_b++;
                if (exp_vec_b.size() == 0) report_fail("vec_b_unexpected_busy");
                else check("vec_b", 32'(vec_b), exp_vec_b.pop_front());
            end
            if (done_b) begin
                check("busy_len_b", busy_cnt_b, LEN_B);
                if (exp_res_b.size() == 0) report_fail("result_b_unexpected_done");
                else check("result_b", 32'(result_b), exp_res_b.pop_front());
            end
            if (!busy_b) busy_cnt_b = 0;
        end
    end

    // ---------------- instance A driver tasks ----------------
    task automatic push_sweep_a();
        exp_res_a.push_back(sweep_model(sel_a, NA, tt_a));
        for (int k = 0; k < (1 << NA); k++)
            for (int h = 0; h < HA; h++) exp_vec_a.push_back(32'(k));
    endtask

    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while ((busy_a || done_a) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) report_fail("wait_idle_a_timeout");
    endtask

    task automatic wait_done_a(output int cd, output bit ok);
        int n = 0;
        ok = 0;
        cd = 0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            if (done_a) begin
                ok = 1;
                cd = cyc;
            end
            n++;
        end
        if (!ok) report_fail("wait_done_a_timeout");
    endtask

    task automatic run_sweep_a(int sel, int extra_start);
        int c0, cd;
        bit ok;
        wait_idle_a();
        sel_a = sel;
        tt_a  = 8'($urandom);
        push_sweep_a();
        start_a = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        if (extra_start > 1) begin
            repeat (extra_start - 2) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        wait_done_a(cd, ok);
        if (ok) check("latency_a", cd - c0, LEN_A);
        if (extra_start > 0) begin
            repeat (5) begin
                @(negedge clk);
                check("no_restart_busy_a", 32'(busy_a), 0);
            end
        end
    endtask

    // ---------------- instance B driver tasks ----------------
    task automatic wait_idle_b();
        int n = 0;
        @(negedge clk);
        while ((busy_b || done_b) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) report_fail("wait_idle_b_timeout");
    endtask

    task automatic run_sweep_b(int sel);
        int c0, cd, n;
        bit ok;
        wait_idle_b();
        sel_b = sel;
        tt_b  = 8'($urandom);
        exp_res_b.push_back(sweep_model(sel_b, NB, tt_b));
        for (int k = 0; k < (1 << NB); k++)
            for (int h = 0; h < HB; h++) exp_vec_b.push_back(32'(k));
        start_b = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk);
        start_b = 1'b0;
        ok = 0;
        n = 0;
        cd = 0;
        while (!ok && n < 200) begin
            if (done_b) begin
                ok = 1;
                cd = cyc;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!ok) report_fail("wait_done_b_timeout");
        else check("latency_b", cd - c0, LEN_B);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cd1, cd2;
        bit ok1, ok2;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sel_a = 0;
        sel_b = 0;
        tt_a = '0;
        tt_b = '0;
        repeat (3) @(negedge clk);
        start_a = 1'b1;            // start during reset must be ignored
        @(negedge clk);
        start_a = 1'b0;
        check("rst_vec_a", 32'(vec_a), 0);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_done_a", 32'(done_a), 0);
        check("rst_result_a", 32'(result_a), 0);
        check("rst_vec_b", 32'(vec_b), 0);
        check("rst_result_b", 32'(result_b), 0);
        rst = 1'b0;

        // Directed gates: AND, XOR, OR
        run_sweep_a(0, 0);
        run_sweep_a(1, 0);
        run_sweep_a(2, 0);

        // Extra start around cycle 15 of a sweep must be ignored
        run_sweep_a(0, 15);

        // Reset mid-sweep, while vec_out == 2
        wait_idle_a();
        sel_a = 0;
        push_sweep_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (23) @(negedge clk);
        check("pre_rst_vec_a", 32'(vec_a), 2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_vec_a", 32'(vec_a), 0);
        check("abort_busy_a", 32'(busy_a), 0);
        check("abort_done_a", 32'(done_a), 0);
        check("abort_result_a", 32'(result_a), 0);
        exp_vec_a.delete();
        exp_res_a.delete();
        rst = 1'b0;
        run_sweep_a(0, 0);

        // Randomized gates / tables
        for (int i = 0; i < 4; i++) run_sweep_a($urandom_range(0, 3), 0);

        // start held high: two back-to-back sweeps
        wait_idle_a();
        sel_a = 0;
        push_sweep_a();
        push_sweep_a();
        start_a = 1'b1;
        wait_done_a(cd1, ok1);
        wait_done_a(cd2, ok2);
        start_a = 1'b0;
        if (ok1 && ok2) check("held_start_interval_a", cd2 - cd1, LEN_A + 2);
        repeat (4) @(negedge clk);
        check("result_hold_a", 32'(result_a), 32'b1000);

        // Instance B: N_IN=3, HOLD=1
        run_sweep_b(0);
        for (int i = 0; i < 5; i++) run_sweep_b($urandom_range(0, 3));

        repeat (5) @(negedge clk);
        check("drain_res_a", exp_res_a.size(), 0);
        check("drain_vec_a", exp_vec_a.size(), 0);
        check("drain_res_b", exp_res_b.size(), 0);
        check("drain_vec_b", exp_vec_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
